main_memory_arbiter: RTL

//  Shares the single-port main-memory block RAM (sync, 1-cycle read latency) between the HC800
//  ram bus (CPU port) and a secondary loader/DMA port (e.g. UART monitor).
//  CPU port has absolute priority and never stalls. The loader uses a valid/ready handshake
//  and is served only in cycles where the CPU does not access memory.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/main_memory_arbiter_if.sv | 24 ++
 rtl/mem_arb_starve_mon.sv | 18 +
 rtl/main_memory_arbiter.sv | 66 ++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding, default widths and the captured loader command type
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 20;
  localparam int MEM_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, PEND, RDATA} state_t;
  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] address;
    logic [MEM_DATA_W-1:0] wdata;
  } ldr_cmd_t;
endpackage

// File: rtl/main_memory_arbiter_if.sv
// main_memory_arbiter_if: CPU ram bus, loader handshake and block-RAM port of the arbiter
interface main_memory_arbiter_if #(
  parameter int ADDR_W     = 20,
  parameter int CPU_ADDR_W = 21,
  parameter int DATA_W     = 8
);
  logic                  cpu_enable, cpu_write;
  logic [CPU_ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0]     cpu_wdata, cpu_rdata;
  logic                  ldr_valid, ldr_ready, ldr_write, ldr_done, ldr_rvalid, ldr_starved;
  logic [ADDR_W-1:0]     ldr_address;
  logic [DATA_W-1:0]     ldr_wdata, ldr_rdata;
  logic                  mem_ena, mem_we;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     mem_din, mem_dout;
  modport slave (
    input  cpu_enable, cpu_write, cpu_address, cpu_wdata, ldr_valid, ldr_write, ldr_address, ldr_wdata, mem_dout,
    output cpu_rdata, ldr_ready, ldr_done, ldr_rvalid, ldr_rdata, ldr_starved, mem_ena, mem_we, mem_address, mem_din
  );
  modport master (
    output cpu_enable, cpu_write, cpu_address, cpu_wdata, ldr_valid, ldr_write, ldr_address, ldr_wdata, mem_dout,
    input  cpu_rdata, ldr_ready, ldr_done, ldr_rvalid, ldr_rdata, ldr_starved, mem_ena, mem_we, mem_address, mem_din
  );
endinterface

// File: rtl/mem_arb_starve_mon.sv
// mem_arb_starve_mon: saturating count of loader cycles blocked by the CPU, flagged at STARVE_LIMIT
module mem_arb_starve_mon #(
  parameter int STARVE_LIMIT = 64
) (
  input  logic bus_clk,
  input  logic bus_reset_n,
  input  logic wait_cycle,
  input  logic clear,
  output logic starved
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] count;
  always_ff @(posedge bus_clk or negedge bus_reset_n)
    if (!bus_reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (wait_cycle && count < CW'(STARVE_LIMIT)) count <= count + 1'b1;
  assign starved = count >= CW'(STARVE_LIMIT);
endmodule

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: CPU-priority sharing of the main-memory BRAM with a loader/DMA port.
// Define MEM_ARB_STARVE_EN to enable the loader starvation monitor (ldr_starved).
module main_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
`ifdef MEM_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 64
`endif
) (
  input logic                  bus_clk,
  input logic                  bus_reset_n,
  main_memory_arbiter_if.slave bus
);
  state_t   state;
  ldr_cmd_t cmd;
  logic     cpu_rd_q, issue;
  assign issue           = state == PEND && !bus.cpu_enable;
  assign bus.mem_ena     = bus.cpu_enable || state == PEND;
  assign bus.mem_we      = bus.cpu_enable ? bus.cpu_write : state == PEND && cmd.write;
  assign bus.mem_address = bus.cpu_enable ? bus.cpu_address[ADDR_W-1:0] : cmd.address;
  assign bus.mem_din     = bus.cpu_enable ? bus.cpu_wdata : cmd.wdata;
  assign bus.cpu_rdata   = cpu_rd_q ? bus.mem_dout : '0;
  always_ff @(posedge bus_clk or negedge bus_reset_n)
    if (!bus_reset_n) begin
      state          <= IDLE;
      cmd            <= '0;
      cpu_rd_q       <= 1'b0;
      bus.ldr_ready  <= 1'b1;
      bus.ldr_done   <= 1'b0;
      bus.ldr_rvalid <= 1'b0;
      bus.ldr_rdata  <= '0;
    end else begin
      cpu_rd_q       <= bus.cpu_enable && !bus.cpu_write;
      bus.ldr_done   <= issue && cmd.write;
      bus.ldr_rvalid <= state == RDATA;
      case (state)
        IDLE: if (bus.ldr_valid) begin
          cmd           <= {bus.ldr_write, bus.ldr_address, bus.ldr_wdata};
          state         <= PEND;
          bus.ldr_ready <= 1'b0;
        end
        PEND: if (issue) begin
          state         <= cmd.write ? IDLE : RDATA;
          bus.ldr_ready <= cmd.write;
        end
        RDATA: begin
          bus.ldr_rdata <= bus.mem_dout;
          state         <= IDLE;
          bus.ldr_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef MEM_ARB_STARVE_EN
  mem_arb_starve_mon #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .bus_clk    (bus_clk),
    .bus_reset_n(bus_reset_n),
    .wait_cycle (state == PEND && bus.cpu_enable),
    .clear      (issue),
    .starved    (bus.ldr_starved)
  );
`else
  assign bus.ldr_starved = 1'b0;
`endif
endmodule
